seven_segment_scan: RTL and testbench
=====================================

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 The module SHALL have parameter DIV, default 4, meaning clock cycles each digit is lit per slot (DIV >= 1).
REQ-002 The module SHALL have parameter DEAD, default 1, meaning all-anodes-off cycles after each lit slot (DEAD >= 0).
REQ-003 The module SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port load_valid  input  1  new display word offered.
REQ-006 The module SHALL have port load_ready  output  1  word accepted when load_valid and load_ready are both high.
REQ-007 The module SHALL have port load_data  input  16  four BCD/hex nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-008 The module SHALL have port load_blank  input  4  per-digit forced blank; bit i blanks digit i.
REQ-009 The module SHALL have port lzb_en  input  1  leading-zero blanking enable, sampled live each cycle.
REQ-010 The module SHALL have port code  output  4  nibble for the shared segment decoder; bit 3 is the MSB.
REQ-011 The module SHALL have port an  output  4  digit enables, active-high, at most one bit set.

Function
REQ-012 Registered state SHALL be: phase (ON/DEAD), idx[1:0], cnt, disp_data[15:0], disp_blank[3:0], pend_data, pend_blank, pending; load_ready, code and an SHALL be combinational from registers and lzb_en only.
REQ-013 In ON, cnt SHALL count 0..DIV-1; at DIV-1 it SHALL clear and go to DEAD, or, if DEAD=0, stay in ON and advance idx.
REQ-014 In DEAD, cnt SHALL count 0..DEAD-1; at DEAD-1 it SHALL clear, go to ON and advance idx.
REQ-015 idx SHALL advance 0->1->2->3->0; the 3->0 transition SHALL be the frame boundary, and the frame length SHALL be 4*(DIV+DEAD) cycles.
REQ-016 load_ready SHALL equal ~pending.
REQ-017 On acceptance, load_data/load_blank SHALL be captured into pend_data/pend_blank and pending SHALL be set.
REQ-018 At the frame-boundary edge with pending=1, disp_data/disp_blank SHALL take the pending values and pending SHALL clear, so digit 0 of the new frame shows the new word.
REQ-019 A word SHALL never be committed mid-frame; at most one word SHALL be pending, and further offers SHALL be stalled via load_ready=0.
REQ-020 Leading-zero blank SHALL apply when lzb_en=1: digit 3 when nibble3==0; digit 2 when nibbles 3 and 2 are 0; digit 1 when nibbles 3, 2 and 1 are 0; digit 0 SHALL never be LZB-blanked.
REQ-021 an[idx] SHALL be 1 only when phase=ON, disp_blank[idx]=0 and idx is not LZB-blanked; all other an bits SHALL be 0.
REQ-022 code SHALL equal disp_data nibble idx whenever an is nonzero, and 4'b0000 otherwise.
REQ-023 Blanked digits SHALL still consume their full slot, so scan timing is independent of data.

Reset
REQ-024 On a clk edge with rst=1: phase=ON, idx=0, cnt=0, disp_data=0, disp_blank=4'b1111, pending=0, pend_*=0.
REQ-025 After reset: an=0, code=0, load_ready=1, so the display is dark until the first commit.
REQ-026 rst SHALL override any concurrent load acceptance or commit; a pending word SHALL be discarded.

Verification (DIV=4, DEAD=1, frame 20 cycles)
REQ-027 Reset, then load 16'h1234 with blank 0 in the cycle after reset (idx=0) -> load_ready=0 until the 3->0 boundary at cycle 20; from then on, each frame shows an=0001/code=4, 0010/3, 0100/2, 1000/1, each 4 cycles followed by 1 cycle an=0.
REQ-028 With lzb_en=1, commit 16'h0050 -> digits 3 and 2 dark (an=0 in their slots), digit 1 shows 5, digit 0 shows 0; with 16'h0000 only digit 0 lit with code=0.
REQ-029 Hold load_valid high with a new word every cycle -> exactly one accept per frame, committed at boundaries only, with no an glitch mid-frame.
REQ-030 Accept a word, then assert rst one cycle before the boundary -> word discarded, display dark, load_ready=1.
REQ-031 With DEAD=0 and DIV=1 -> idx advances every cycle, an rotates 0001, 0010, 0100, 1000 with no off cycles, and a commit lands on the 3->0 edge.
REQ-032 Commit load_blank=4'b0101 on 16'h8888 -> only an=0010 and an=1000 ever assert, each with code=8.

Source files
------------

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed 4-digit seven-segment scanner with frame-aligned word commit
module seven_segment_scan #(
    parameter int DIV  = 4,
    parameter int DEAD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_blank,
    input  logic        lzb_en,
    output logic [3:0]  code,
    output logic [3:0]  an
);

    localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic {
        PH_ON   = 1'b0,
        PH_DEAD = 1'b1
    } phase_t;

    phase_t        phase_q, phase_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_end;

    logic [15:0]   disp_data;
    logic [3:0]    disp_blank;
    logic [15:0]   pend_data;
    logic [3:0]    pend_blank;
    logic          pending;

    logic [3:0]    lzb;
    logic [3:0]    dark;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_ON;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            disp_data  <= 16'h0000;
            disp_blank <= 4'b1111;
            pend_data  <= 16'h0000;
            pend_blank <= 4'b0000;
            pending    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            // Accept and commit are mutually exclusive: accept needs pending=0, commit needs pending=1.
            if (load_valid && !pending) begin
                pend_data  <= load_data;
                pend_blank <= load_blank;
                pending    <= 1'b1;
            end
            if (frame_end && pending) begin
                disp_data  <= pend_data;
                disp_blank <= pend_blank;
                pending    <= 1'b0;
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CW'(1);
        frame_end = 1'b0;
        if (phase_q == PH_ON) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                if (DEAD == 0) begin
                    idx_d     = idx_q + 2'd1;
                    frame_end = (idx_q == 2'd3);
                end else begin
                    phase_d = PH_DEAD;
                end
            end
        end else begin
            if (cnt_q == CW'(DEAD - 1)) begin
                cnt_d     = '0;
                phase_d   = PH_ON;
                idx_d     = idx_q + 2'd1;
                frame_end = (idx_q == 2'd3);
            end
        end
    end

    // Leading-zero chain from the top digit down; digit 0 always shows.
    always_comb begin
        lzb    = 4'b0000;
        lzb[3] = lzb_en && (disp_data[15:12] == 4'h0);
        lzb[2] = lzb[3] && (disp_data[11:8] == 4'h0);
        lzb[1] = lzb[2] && (disp_data[7:4] == 4'h0);
        dark   = disp_blank | lzb;
    end

    always_comb begin
        an   = 4'b0000;
        code = 4'b0000;
        if (phase_q == PH_ON && !dark[idx_q]) begin
            an[idx_q] = 1'b1;
            code      = disp_data[{idx_q, 2'b00} +: 4];
        end
    end

    assign load_ready = ~pending;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - bench for seven_segment_scan
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_blank = 4'h0;
    logic        lzb_en = 1'b0;
    logic [3:0]  code, an;

    logic        rst1 = 1'b1;
    logic        lv1 = 1'b0;
    logic        lr1;
    logic [15:0] ld1 = 16'h0000;
    logic [3:0]  code1, an1;

    seven_segment_scan #(.DIV(4), .DEAD(1)) u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_blank(load_blank), .lzb_en(lzb_en),
        .code(code), .an(an)
    );

    seven_segment_scan #(.DIV(1), .DEAD(0)) u1 (
        .clk(clk), .rst(rst1), .load_valid(lv1), .load_ready(lr1),
        .load_data(ld1), .load_blank(4'b0000), .lzb_en(1'b0),
        .code(code1), .an(an1)
    );

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [3:0] code;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  blank;
        logic        lzb;
        logic [15:0] an_e;
        logic [15:0] code_e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   acc_cnt = 0;

    always @(posedge clk)
        if (!rst && load_valid && load_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @cyc %0d actual=%h required=%h", nm, cyc, act, req);
    endtask

    // One slot = 4 lit cycles then 1 dark cycle; an_e/code_e hold the per-slot nibble.
    task automatic push_frame(input int f, input logic [15:0] an_e, input logic [15:0] code_e,
                              input logic rdy_first, input logic rdy_rest);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 5; w++) begin
                e.at   = f + s * 5 + w;
                e.an   = (w < 4) ? an_e[s*4 +: 4] : 4'h0;
                e.code = (w < 4) ? code_e[s*4 +: 4] : 4'h0;
                e.rdy  = (s == 0 && w == 0) ? rdy_first : rdy_rest;
                sb.push_back(e);
            end
        end
    endtask

    task automatic cyc_step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) chk("sb_order", 16'(e.at), 16'(cyc));
            else begin
                chk("an", {12'h0, an}, {12'h0, e.an});
                chk("code", {12'h0, code}, {12'h0, e.code});
                chk("load_ready", {15'h0, load_ready}, {15'h0, e.rdy});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [15:0] word(input int c);
        return 16'hA000 | 16'(c & 12'hFFF);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int f;
        int a0;
        logic [15:0] prev_an, prev_code;

        vt[0] = '{16'h1234, 4'b0000, 1'b0, 16'h8421, 16'h1234};
        vt[1] = '{16'h0050, 4'b0000, 1'b1, 16'h0021, 16'h0050};
        vt[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0001, 16'h0000};
        vt[3] = '{16'h8888, 4'b0101, 1'b0, 16'h8020, 16'h8080};
        vt[4] = '{16'h0050, 4'b0000, 1'b0, 16'h8421, 16'h0050};
        vt[5] = '{16'h0F00, 4'b0000, 1'b1, 16'h0421, 16'h0F00};
        vt[6] = '{16'h1000, 4'b0000, 1'b1, 16'h8421, 16'h1000};
        vt[7] = '{16'h0001, 4'b1000, 1'b1, 16'h0001, 16'h0001};
        vt[8] = '{16'h1234, 4'b0001, 1'b1, 16'h8420, 16'h1230};

        do_reset();
        f = 0;
        prev_an = 16'h0000;
        prev_code = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_data  = vt[i].data;
            load_blank = vt[i].blank;
            push_frame(f, prev_an, prev_code, 1'b1, 1'b0);
            push_frame(f + 20, vt[i].an_e, vt[i].code_e, 1'b1, 1'b1);
            cyc_step();
            load_valid = 1'b0;
            while (cyc < f + 19) cyc_step();
            lzb_en = vt[i].lzb;
            while (cyc < f + 40) cyc_step();
            prev_an = vt[i].an_e;
            prev_code = vt[i].code_e;
            f += 40;
        end

        // Continuous offers: one accept per frame, commits only on frame boundaries.
        load_blank = 4'b0000;
        push_frame(f, prev_an, prev_code, 1'b1, 1'b0);
        push_frame(f + 20, 16'h8421, word(f), 1'b1, 1'b0);
        push_frame(f + 40, 16'h8421, word(f + 20), 1'b1, 1'b0);
        a0 = acc_cnt;
        while (cyc < f + 60) begin
            load_valid = (cyc <= f + 40);
            load_data  = word(cyc);
            cyc_step();
        end
        load_valid = 1'b0;
        chk("accepts_per_frame", 16'(acc_cnt - a0), 16'd3);

        // Reset one cycle before the boundary discards the pending word.
        do_reset();
        lzb_en = 1'b0;
        load_valid = 1'b1;
        load_data = 16'h1234;
        push_frame(0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cyc_step();
        load_valid = 1'b0;
        while (cyc < 19) cyc_step();
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        cyc = 0;
        push_frame(0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        push_frame(20, 16'h0000, 16'h0000, 1'b1, 1'b1);
        while (cyc < 40) cyc_step();

        // DIV=1, DEAD=0: four-cycle frame, no dark cycles.
        rst1 = 1'b0;
        lv1 = 1'b1;
        ld1 = 16'h4321;
        for (int c = 0; c < 12; c++) begin
            logic [3:0] ea, ec;
            logic       er;
            ea = (c < 4) ? 4'h0 : (4'h1 << (c % 4));
            ec = (c < 4) ? 4'h0 : 4'((c % 4) + 1);
            er = (c == 0) || (c >= 4);
            @(negedge clk);
            chk("u1_an", {12'h0, an1}, {12'h0, ea});
            chk("u1_code", {12'h0, code1}, {12'h0, ec});
            chk("u1_load_ready", {15'h0, lr1}, {15'h0, er});
            @(posedge clk);
            #1;
            lv1 = 1'b0;
        end

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
